tile_reader: RTL and testbench

TILE_READER -- requirements
Module: tile_reader

---
 rtl/tile_pkg.sv | 21 ++
 rtl/skid_fifo2.sv | 68 ++++++
 rtl/tile_reader.sv | 143 ++++++++++++++
 tb/tb_tile_reader.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// rtl/tile_pkg.sv - shared types and helpers for the tile reader
// Contents:
//   state_e  : tile reader FSM states
//   clog2z   : ceil(log2(n)), never smaller than 1, for index widths
package tile_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  function automatic int clog2z(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/skid_fifo2.sv
// rtl/skid_fifo2.sv - two-entry skid FIFO between buffer reads and the output stream
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   push        : write push_data this cycle
//   push_data   : entry to store
//   pop         : consume head entry (ignored when empty)
//   occ         : current occupancy, 0..2
//   head_data   : oldest entry, stable until popped
//   head_valid  : head_data holds a real entry
module skid_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   occ,
  output logic [W-1:0] head_data,
  output logic         head_valid
);

  logic [W-1:0] e0_q;
  logic [W-1:0] e1_q;
  logic [1:0]   occ_q;
  logic         pop_ok;

  assign pop_ok     = pop & (occ_q != 2'd0);
  assign occ        = occ_q;
  assign head_data  = e0_q;
  assign head_valid = (occ_q != 2'd0);

  // e0_q is always the head, so the head only moves on a pop or on a push
  // into an empty buffer; that keeps the output stable under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      e0_q  <= '0;
      e1_q  <= '0;
      occ_q <= 2'd0;
    end else begin
      case ({push, pop_ok})
        2'b10: begin
          if (occ_q == 2'd0) begin
            e0_q  <= push_data;
            occ_q <= 2'd1;
          end else if (occ_q == 2'd1) begin
            e1_q  <= push_data;
            occ_q <= 2'd2;
          end
        end
        2'b01: begin
          e0_q  <= e1_q;
          occ_q <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            e0_q <= push_data;
          end else begin
            e0_q <= e1_q;
            e1_q <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/tile_reader.sv
// rtl/tile_reader.sv - streams one WIDTH x HEIGHT tile from a result buffer
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start     : request one tile (honoured only when idle)
//   busy      : tile in progress, through the done cycle
//   done      : one-cycle pulse after the last beat is accepted
//   rd_en     : buffer read strobe
//   rd_addr   : buffer address, row*WIDTH + col
//   rd_data   : buffer data, one cycle after rd_en
//   m_tdata   : output stream data
//   m_tvalid  : output beat valid
//   m_tready  : downstream accept
//   m_tlast   : last element of a row
module tile_reader
  import tile_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int HEIGHT = 32,
  parameter int DATA_W = 32,
  localparam int CW = clog2z(WIDTH),
  localparam int RW = clog2z(HEIGHT),
  localparam int AW = clog2z(WIDTH * HEIGHT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [AW-1:0]     rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast
);

  state_e        state_q;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic [AW-1:0] addr_q;
  logic          inflight_q;
  logic          last_q;
  logic          busy_q;
  logic          done_q;

  logic [1:0]        occ;
  logic [DATA_W:0]   head;
  logic              head_valid;
  logic              pop;
  logic              col_last;
  logic              row_last;
  logic              final_pop;
  logic [2:0]        fill;
  logic [2:0]        room;

  assign col_last = (col_q == CW'(WIDTH - 1));
  assign row_last = (row_q == RW'(HEIGHT - 1));

  assign m_tvalid = head_valid;
  assign m_tdata  = head[DATA_W-1:0];
  assign m_tlast  = head[DATA_W];
  assign pop      = m_tvalid & m_tready;

  // occ + inflight - pop < 2, rearranged to stay unsigned.
  assign fill  = {1'b0, occ} + {2'b00, inflight_q};
  assign room  = 3'd2 + {2'b00, pop};
  assign rd_en = (state_q == S_READ) && (fill < room);

  // Once in FLUSH nothing new is issued, so the tile's final beat is the pop
  // that empties the buffer with no read still returning.
  assign final_pop = pop && (occ == 2'd1) && !inflight_q;

  assign rd_addr = addr_q;
  assign busy    = busy_q;
  assign done    = done_q;

  skid_fifo2 #(.W(DATA_W + 1)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .push       (inflight_q),
    .push_data  ({last_q, rd_data}),
    .pop        (pop),
    .occ        (occ),
    .head_data  (head),
    .head_valid (head_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      inflight_q <= rd_en;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_READ;
            col_q   <= '0;
            row_q   <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_READ: begin
          if (rd_en) begin
            addr_q <= addr_q + AW'(1);
            last_q <= col_last;
            if (col_last) begin
              col_q <= '0;
              if (row_last) begin
                state_q <= S_FLUSH;
              end else begin
                row_q <= row_q + RW'(1);
              end
            end else begin
              col_q <= col_q + CW'(1);
            end
          end
        end
        S_FLUSH: begin
          if (final_pop) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_reader.sv
// tb/tb_tile_reader.sv - scoreboard bench for tile_reader (4x2 and 1x3 tiles)
module tb_tile_reader;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       fin;
    int         idx;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic       busy_a, done_a, rd_en_a, m_tvalid_a, m_tlast_a;
  logic       m_tready_a = 1'b1;
  logic [2:0] rd_addr_a;
  logic [7:0] rd_data_a = 8'd0, m_tdata_a;
  logic       busy_b, done_b, rd_en_b, m_tvalid_b, m_tlast_b;
  logic       m_tready_b = 1'b1;
  logic [1:0] rd_addr_b;
  logic [7:0] rd_data_b = 8'd0, m_tdata_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mode_a = 0;  // 0: ready=1, 1: toggle, 2: ready=0, 3: random
  beat_t qa[$];
  beat_t qb[$];
  logic done_due_a = 1'b0, done_due_b = 1'b0;
  int out_a = 0, beats_a = 0, first_a = 0, last_a = 0;
  logic [2:0] exp_addr_a = 3'd0;
  logic [1:0] exp_addr_b = 2'd0;

  tile_reader #(.WIDTH(4), .HEIGHT(2), .DATA_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .m_tdata(m_tdata_a), .m_tvalid(m_tvalid_a), .m_tready(m_tready_a), .m_tlast(m_tlast_a)
  );

  tile_reader #(.WIDTH(1), .HEIGHT(3), .DATA_W(8)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .m_tdata(m_tdata_b), .m_tvalid(m_tvalid_b), .m_tready(m_tready_b), .m_tlast(m_tlast_b)
  );

  // Result buffers: data equals address, one cycle after the read strobe.
  always @(posedge clk) begin
    if (rd_en_a) rd_data_a <= {5'd0, rd_addr_a};
    if (rd_en_b) rd_data_b <= {6'd0, rd_addr_b};
  end

  always @(posedge clk) begin
    #1;
    case (mode_a)
      0: m_tready_a = 1'b1;
      1: m_tready_a = ~m_tready_a;
      2: m_tready_a = 1'b0;
      default: m_tready_a = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic fail(input string name, input int act, input int req);
    failures++;
    $display("FAIL %s actual=%0d required=%0d", name, act, req);
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) fail(name, act, req);
  endtask

  // Monitor for the 4x2 instance: order, hold-under-stall, address order,
  // outstanding-read bound and done timing.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      qa.delete();
      done_due_a = 1'b0;
      out_a = 0;
      exp_addr_a = 3'd0;
    end else begin
      chk("done_a", int'(done_a), int'(done_due_a));
      chk("outstanding_a", int'(out_a <= 2), 1);
      if (rd_en_a) begin
        chk("rd_addr_a", int'(rd_addr_a), int'(exp_addr_a));
        exp_addr_a = exp_addr_a + 3'd1;
      end
      done_due_a = 1'b0;
      if (m_tvalid_a) begin
        if (qa.size() == 0) begin
          checks++;
          fail("unexpected_beat_a", int'(m_tdata_a), -1);
        end else begin
          chk("tdata_a", int'(m_tdata_a), int'(qa[0].data));
          chk("tlast_a", int'(m_tlast_a), int'(qa[0].last));
          if (m_tready_a) begin
            if (qa[0].idx == 0) first_a = cyc;
            last_a = cyc;
            done_due_a = qa[0].fin;
            void'(qa.pop_front());
            beats_a++;
          end
        end
      end
      out_a = out_a + int'(rd_en_a) - int'(m_tvalid_a & m_tready_a);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      qb.delete();
      done_due_b = 1'b0;
      exp_addr_b = 2'd0;
    end else begin
      chk("done_b", int'(done_b), int'(done_due_b));
      if (rd_en_b) begin
        chk("rd_addr_b", int'(rd_addr_b), int'(exp_addr_b));
        exp_addr_b = exp_addr_b + 2'd1;
      end
      done_due_b = 1'b0;
      if (m_tvalid_b && m_tready_b) begin
        if (qb.size() == 0) begin
          checks++;
          fail("unexpected_beat_b", int'(m_tdata_b), -1);
        end else begin
          chk("tdata_b", int'(m_tdata_b), int'(qb[0].data));
          chk("tlast_b", int'(m_tlast_b), int'(qb[0].last));
          done_due_b = qb[0].fin;
          void'(qb.pop_front());
        end
      end
    end
  end

  // Expected tile: element i sits at row i/W, col i%W; row ends carry tlast.
  task automatic start_tile_a();
    beat_t b;
    for (int i = 0; i < 8; i++) begin
      b.data = 8'(i); b.last = ((i % 4) == 3); b.fin = (i == 7); b.idx = i;
      qa.push_back(b);
    end
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  task automatic finish_a(input string tag);
    int n;
    n = 0;
    while (qa.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (qa.size() != 0) begin
      checks++;
      fail({"timeout_", tag}, qa.size(), 0);
      qa.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    beat_t b;
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_rd_en", int'(rd_en_a), 0);
    chk("rst_rd_addr", int'(rd_addr_a), 0);
    chk("rst_tvalid", int'(m_tvalid_a), 0);
    chk("rst_tlast", int'(m_tlast_a), 0);
    chk("rst_tdata", int'(m_tdata_a), 0);
    chk("rst_tvalid_b", int'(m_tvalid_b), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Full-rate streaming
    mode_a = 0;
    start_tile_a();
    chk("busy_during_tile", int'(busy_a), 1);
    finish_a("full_rate");
    chk("full_rate_no_gaps", last_a - first_a, 7);
    chk("busy_after_tile", int'(busy_a), 0);

    // Alternating backpressure
    mode_a = 1;
    repeat (2) @(posedge clk);
    #1;
    start_tile_a();
    finish_a("toggle");

    // Long stall right after start, then release
    mode_a = 2;
    repeat (2) @(posedge clk);
    #1;
    start_tile_a();
    repeat (10) @(posedge clk);
    #1;
    chk("stall_outstanding", out_a, 2);
    mode_a = 0;
    finish_a("stall_release");
    chk("release_no_gaps", last_a - first_a, 7);

    // start re-pulsed mid-tile must be ignored
    mode_a = 3;
    start_tile_a();
    repeat (4) @(posedge clk);
    #1;
    if (qa.size() > 0) begin
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
    end
    finish_a("repulse");

    // Reset after beat 4, then a clean tile from address 0
    mode_a = 0;
    repeat (2) @(posedge clk);
    #1;
    beats_a = 0;
    start_tile_a();
    n = 0;
    while (beats_a < 5 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("beats_before_rst", beats_a, 5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("tvalid_after_mid_rst", int'(m_tvalid_a), 0);
    chk("busy_after_mid_rst", int'(busy_a), 0);
    repeat (4) @(posedge clk);
    #1;
    start_tile_a();
    finish_a("after_rst");

    // Randomised tiles with random backpressure and stray start pulses
    for (int t = 0; t < 6; t++) begin
      mode_a = 3;
      start_tile_a();
      repeat ($urandom_range(1, 8)) @(posedge clk);
      #1;
      if (qa.size() > 0 && $urandom_range(0, 1) == 1) begin
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
      end
      finish_a("random");
    end

    // Single-column tile: every beat is a row end
    for (int i = 0; i < 3; i++) begin
      b.data = 8'(i); b.last = 1'b1; b.fin = (i == 2); b.idx = i;
      qb.push_back(b);
    end
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    n = 0;
    while (qb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("tile_b_drained", qb.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("tile_b_addr_count", int'(exp_addr_b), 3);
    chk("tile_b_busy_end", int'(busy_b), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
